// File: rtl/reg_file_scoreboard.sv
// Register file with per-register busy scoreboard, 2 read / 1 write ports.
// Latency: operands are registered, valid 1 cycle after issue accept; writeback bypasses into the read.
// Backpressure: issue_ready drops on RAW/WAW against a busy register not being written back this cycle.
module reg_file_scoreboard #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int ZERO_REG   = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            issue_valid,
    output logic                            issue_ready,
    input  logic [ADDR_WIDTH-1:0]           rs1,
    input  logic [ADDR_WIDTH-1:0]           rs2,
    input  logic [ADDR_WIDTH-1:0]           rd,
    input  logic                            rs1_used,
    input  logic                            rs2_used,
    input  logic                            rd_we,
    output logic                            op_valid,
    output logic [DATA_WIDTH-1:0]           rs1_data,
    output logic [DATA_WIDTH-1:0]           rs2_data,
    input  logic                            wb_valid,
    input  logic [ADDR_WIDTH-1:0]           wb_rd,
    input  logic [DATA_WIDTH-1:0]           wb_data,
    output logic                            wb_err,
    output logic [(2**ADDR_WIDTH)-1:0]      busy_vec,
    output logic [CNT_WIDTH-1:0]            stall_cycles
);

    localparam int REG_COUNT = 2**ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
    logic [REG_COUNT-1:0]  busy_q, busy_d;
    logic                  op_valid_q, op_valid_d;
    logic [DATA_WIDTH-1:0] rs1_data_q, rs1_data_d;
    logic [DATA_WIDTH-1:0] rs2_data_q, rs2_data_d;
    logic                  wb_err_q, wb_err_d;
    logic [CNT_WIDTH-1:0]  stall_q, stall_d;

    logic raw1, raw2, waw, accept;

    function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    function automatic logic wb_hit(input logic [ADDR_WIDTH-1:0] a);
        return wb_valid && (wb_rd == a);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] a);
        if (is_zero(a))
            return '0;
        else if (wb_hit(a))
            return wb_data;
        else
            return regs_q[a];
    endfunction

    always_comb begin
        raw1        = rs1_used && busy_q[rs1] && !wb_hit(rs1);
        raw2        = rs2_used && busy_q[rs2] && !wb_hit(rs2);
        waw         = rd_we    && busy_q[rd]  && !wb_hit(rd);
        issue_ready = !(raw1 || raw2 || waw);
        accept      = issue_valid && issue_ready;
    end

    always_comb begin
        op_valid_d = accept;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        if (accept) begin
            rs1_data_d = read_port(rs1);
            rs2_data_d = read_port(rs2);
        end

        wb_err_d = wb_valid && !busy_q[wb_rd] && !is_zero(wb_rd);

        // Clear first so a same-cycle issue to the same register leaves it outstanding.
        busy_d = busy_q;
        if (wb_valid)
            busy_d[wb_rd] = 1'b0;
        if (accept && rd_we && !is_zero(rd))
            busy_d[rd] = 1'b1;
        if (ZERO_REG != 0)
            busy_d[0] = 1'b0;

        stall_d = stall_q;
        if (issue_valid && !issue_ready && (stall_q != {CNT_WIDTH{1'b1}}))
            stall_d = stall_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= '0;
            op_valid_q <= 1'b0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            wb_err_q   <= 1'b0;
            stall_q    <= '0;
        end else begin
            busy_q     <= busy_d;
            op_valid_q <= op_valid_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            wb_err_q   <= wb_err_d;
            stall_q    <= stall_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++)
                regs_q[i] <= '0;
        end else if (wb_valid && !is_zero(wb_rd)) begin
            regs_q[wb_rd] <= wb_data;
        end
    end

    assign op_valid     = op_valid_q;
    assign rs1_data     = rs1_data_q;
    assign rs2_data     = rs2_data_q;
    assign wb_err       = wb_err_q;
    assign busy_vec     = busy_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Bench for reg_file_scoreboard: reference model plus operand scoreboard, directed hazard cases, random traffic.
module tb_reg_file_scoreboard;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int CW = 8;
    localparam int RC = 2**AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          issue_valid = 1'b0;
    logic          issue_ready;
    logic [AW-1:0] rs1 = '0, rs2 = '0, rd = '0;
    logic          rs1_used = 1'b0, rs2_used = 1'b0, rd_we = 1'b0;
    logic          op_valid;
    logic [DW-1:0] rs1_data, rs2_data;
    logic          wb_valid = 1'b0;
    logic [AW-1:0] wb_rd = '0;
    logic [DW-1:0] wb_data = '0;
    logic          wb_err;
    logic [RC-1:0] busy_vec;
    logic [CW-1:0] stall_cycles;

    always #5 clk = ~clk;

    reg_file_scoreboard #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ZERO_REG(1), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .rs1(rs1), .rs2(rs2), .rd(rd),
        .rs1_used(rs1_used), .rs2_used(rs2_used), .rd_we(rd_we),
        .op_valid(op_valid), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_err(wb_err), .busy_vec(busy_vec), .stall_cycles(stall_cycles)
    );

    // Reference model state, advanced on the same edges as the DUT.
    logic [DW-1:0]     m_regs [RC];
    logic [RC-1:0]     m_busy = '0;
    logic              exp_opv = 1'b0;
    logic              exp_err = 1'b0;
    logic [CW-1:0]     m_stall = '0;
    logic [2*DW-1:0]   opq [$];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic logic m_hit(input logic [AW-1:0] a);
        return wb_valid && (wb_rd == a);
    endfunction

    function automatic logic m_ready();
        logic r1, r2, w;
        r1 = rs1_used && m_busy[rs1] && !m_hit(rs1);
        r2 = rs2_used && m_busy[rs2] && !m_hit(rs2);
        w  = rd_we    && m_busy[rd]  && !m_hit(rd);
        return !(r1 || r2 || w);
    endfunction

    function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
        if (a == '0)      return '0;
        else if (m_hit(a)) return wb_data;
        else              return m_regs[a];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RC; i++) m_regs[i] = '0;
            m_busy  = '0;
            exp_opv = 1'b0;
            exp_err = 1'b0;
            m_stall = '0;
            opq.delete();
        end else begin
            logic rdy, acc;
            rdy     = m_ready();
            acc     = issue_valid && rdy;
            exp_opv = acc;
            if (acc) opq.push_back({m_read(rs1), m_read(rs2)});
            exp_err = wb_valid && !m_busy[wb_rd] && (wb_rd != '0);
            if (issue_valid && !rdy && (m_stall != {CW{1'b1}})) m_stall = m_stall + 1'b1;
            if (wb_valid) begin
                if (wb_rd != '0) m_regs[wb_rd] = wb_data;
                m_busy[wb_rd] = 1'b0;
            end
            if (acc && rd_we && (rd != '0)) m_busy[rd] = 1'b1;
        end
    end

    task automatic check_outputs();
        logic [2*DW-1:0] e;
        chk("op_valid", op_valid, exp_opv);
        if (exp_opv && opq.size() > 0) begin
            e = opq.pop_front();
            chk("sb_rs1_data", rs1_data, e[2*DW-1:DW]);
            chk("sb_rs2_data", rs2_data, e[DW-1:0]);
        end
        chk("wb_err", wb_err, exp_err);
        chk("busy_vec", busy_vec, m_busy);
        chk("stall_cycles", stall_cycles, m_stall);
    endtask

    // One cycle: check registered outputs, drive new inputs, check combinational ready.
    task automatic cyc(input logic iv, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                       input logic [AW-1:0] ad, input logic u1, input logic u2, input logic we,
                       input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        @(negedge clk);
        check_outputs();
        issue_valid = iv; rs1 = a1; rs2 = a2; rd = ad;
        rs1_used = u1; rs2_used = u2; rd_we = we;
        wb_valid = wv; wb_rd = wa; wb_data = wd;
        #1 chk("issue_ready", issue_ready, m_ready());
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #10;
        chk("rst_op_valid", op_valid, 0);
        chk("rst_busy", busy_vec, 0);
        chk("rst_stall", stall_cycles, 0);
        chk("rst_wb_err", wb_err, 0);
        chk("rst_rs1_data", rs1_data, 0);
        @(negedge clk) rst_n = 1'b1;

        // x0 and a never-written register read as zero
        cyc(1, 0, 5, 0, 1, 1, 0, 0, 0, 0);
        after_edge();
        chk("first_op_valid", op_valid, 1);
        chk("first_rs1", rs1_data, 0);
        chk("first_rs2", rs2_data, 0);
        chk("first_busy", busy_vec, 0);

        // writeback to a non-busy register
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 5, 32'h1234);
        after_edge();
        chk("wb_err_pulse", wb_err, 1);
        cyc(1, 0, 5, 0, 0, 1, 0, 0, 0, 0);
        after_edge();
        chk("wb_err_once", wb_err, 0);
        chk("rs2_after_wb", rs2_data, 32'h1234);

        // RAW stall then bypass release
        cyc(1, 0, 0, 7, 0, 0, 1, 0, 0, 0);
        after_edge();
        chk("busy7_set", busy_vec[7], 1);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 7, 0, 0, 1, 0, 0, 0, 0, 0);
            chk("raw_ready", issue_ready, 0);
        end
        after_edge();
        chk("stall_3", stall_cycles, 3);
        cyc(1, 7, 0, 0, 1, 0, 0, 1, 7, 32'hCAFE);
        chk("raw_bypass_ready", issue_ready, 1);
        after_edge();
        chk("raw_bypass_data", rs1_data, 32'hCAFE);
        chk("busy7_clear", busy_vec[7], 0);

        // WAW: set wins over same-cycle clear
        cyc(1, 0, 0, 9, 0, 0, 1, 0, 0, 0);
        cyc(1, 0, 0, 9, 0, 0, 1, 0, 0, 0);
        chk("waw_ready", issue_ready, 0);
        cyc(1, 0, 0, 9, 0, 0, 1, 1, 9, 32'h99);
        chk("waw_wb_ready", issue_ready, 1);
        after_edge();
        chk("waw_busy9", busy_vec[9], 1);
        chk("waw_no_err", wb_err, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 9, 32'h77);

        // x0 never busy, never written, no error
        cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        after_edge();
        chk("x0_not_busy", busy_vec, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hFFFF);
        after_edge();
        chk("x0_no_err", wb_err, 0);
        cyc(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        after_edge();
        chk("x0_reads_zero", rs1_data, 0);

        // random traffic over a small register window to provoke hazards
        for (int i = 0; i < 300; i++) begin
            cyc($urandom_range(0, 1), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                AW'($urandom_range(0, 7)), $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 1), ($urandom_range(0, 2) == 0),
                AW'($urandom_range(0, 7)), $urandom);
        end
        // drain outstanding writers
        for (int r = 0; r < 8; r++)
            cyc(0, 0, 0, 0, 0, 0, 0, 1, AW'(r), DW'(r));
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        after_edge();
        chk("drained_busy", busy_vec, 0);

        // saturation with a permanently blocked source
        cyc(1, 0, 0, 3, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < (2**CW) + 5; i++)
            cyc(1, 3, 0, 0, 1, 0, 0, 0, 0, 0);
        after_edge();
        chk("stall_saturated", stall_cycles, {CW{1'b1}});
        chk("busy3_pending", busy_vec[3], 1);

        // asynchronous reset mid-cycle clears immediately
        #2 rst_n = 1'b0;
        issue_valid = 1'b0;
        #1;
        chk("async_rst_stall", stall_cycles, 0);
        chk("async_rst_busy", busy_vec, 0);
        chk("async_rst_opv", op_valid, 0);
        @(negedge clk) rst_n = 1'b1;
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 3, 32'h5);
        after_edge();
        chk("post_rst_wb_err", wb_err, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("queue_empty", opq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
